// File: rtl/note_scheduler.sv
// Beat-paced chart sequencer: fetches one row of the 5-lane note map per tick into a
// scrolling window, then scrolls WINDOW blank rows through before signalling done.
module note_scheduler #(
  parameter int TICK_DIV = 25_000_000,
  parameter int WINDOW   = 8,
  parameter int LANES    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      abort,
  input  logic [10:0]               map_len,
  output logic [99:0]               index_y,
  output logic [2:0]                index_x,
  input  logic [2:0]                data_state,
  output logic [WINDOW*LANES*3-1:0] window,
  output logic [10:0]               row_ptr,
  output logic                      row_strobe,
  output logic                      busy,
  output logic                      done
);
  localparam int ROW_W = LANES * 3;
  localparam int WIN_W = WINDOW * ROW_W;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int DRN_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(WINDOW - 1);
  localparam logic [2:0]       ADDR_LAST  = 3'(LANES - 1);
  localparam logic [2:0]       FETCH_LAST = 3'(LANES + 1);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, FETCH, COMMIT, DRAIN_WAIT, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f_q;
  logic [DRN_W-1:0] drain_q;
  logic [ROW_W-4:0] asm_q;
  logic [WIN_W-1:0] window_q;
  logic [10:0]      row_ptr_q;
  logic [10:0]      index_y_q;
  logic [2:0]       index_x_q;
  logic             row_strobe_q;
  logic             done_q;

  logic             counting;
  logic             tick;
  logic [ROW_W-1:0] commit_row;

  assign counting   = (state_q == WAIT_TICK || state_q == DRAIN_WAIT) && !pause;
  assign tick       = counting && (cnt_q == TICK_LAST);
  // The last lane is still on the ROM output during the final fetch cycle.
  assign commit_row = {data_state, asm_q};

  assign index_y    = 100'(index_y_q);
  assign index_x    = index_x_q;
  assign window     = window_q;
  assign row_ptr    = row_ptr_q;
  assign row_strobe = row_strobe_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  // NOTE: the window is a bank of flops, not a RAM, so it is cleared on reset like any
  // other register and the renderer never sees undefined lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      f_q          <= '0;
      drain_q      <= '0;
      asm_q        <= '0;
      window_q     <= '0;
      row_ptr_q    <= '0;
      index_y_q    <= '0;
      index_x_q    <= '0;
      row_strobe_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here; later assignments in the same block win.
      row_strobe_q <= 1'b0;
      done_q       <= 1'b0;
      if (counting) cnt_q <= tick ? '0 : cnt_q + 1'b1;

      if (abort && state_q != IDLE) begin
        state_q   <= IDLE;
        window_q  <= '0;
        row_ptr_q <= '0;
        cnt_q     <= '0;
        f_q       <= '0;
        drain_q   <= '0;
        index_y_q <= '0;
        index_x_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q   <= WAIT_TICK;
              row_ptr_q <= '0;
              cnt_q     <= '0;
              drain_q   <= '0;
              window_q  <= '0;
            end
          end
          WAIT_TICK, DRAIN_WAIT: begin
            if (tick && state_q == WAIT_TICK && row_ptr_q < map_len) begin
              state_q   <= FETCH;
              f_q       <= '0;
              index_y_q <= row_ptr_q;
              index_x_q <= '0;
            end else if (tick) begin
              // Chart exhausted: every tick scrolls in a blank row until the window is empty.
              window_q     <= {window_q[WIN_W-ROW_W-1:0], {ROW_W{1'b0}}};
              row_strobe_q <= 1'b1;
              if (drain_q == DRAIN_LAST) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= DRAIN_WAIT;
                drain_q <= drain_q + 1'b1;
              end
            end
          end
          FETCH: begin
            f_q       <= f_q + 1'b1;
            index_x_q <= (f_q < ADDR_LAST) ? f_q + 1'b1 : 3'd0;
            if (f_q >= 3'd2 && f_q != FETCH_LAST) asm_q <= {data_state, asm_q[ROW_W-4:3]};
            if (f_q == FETCH_LAST) begin
              state_q      <= COMMIT;
              window_q     <= {window_q[WIN_W-ROW_W-1:0], commit_row};
              row_ptr_q    <= row_ptr_q + 1'b1;
              row_strobe_q <= 1'b1;
            end
          end
          COMMIT:  state_q <= WAIT_TICK;
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler: a 2-cycle-latency ROM model, a table of
// first-row vectors, hand-built corner sequences and randomized playbacks.
module tb_note_scheduler;
  localparam int TICK_DIV = 8;
  localparam int WINDOW   = 8;
  localparam int LANES    = 5;
  localparam int ROW_W    = LANES * 3;
  localparam int WIN_W    = WINDOW * ROW_W;
  localparam int NROWS    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic [10:0]      map_len = '0;
  logic [99:0]      index_y;
  logic [2:0]       index_x;
  logic [2:0]       data_state = '0;
  logic [WIN_W-1:0] window;
  logic [10:0]      row_ptr;
  logic             row_strobe;
  logic             busy;
  logic             done;

  note_scheduler #(.TICK_DIV(TICK_DIV), .WINDOW(WINDOW), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .map_len(map_len), .index_y(index_y), .index_x(index_x), .data_state(data_state),
    .window(window), .row_ptr(row_ptr), .row_strobe(row_strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Map ROM model: registered output, data for an address appears two cycles later.
  logic [2:0] rom [NROWS][LANES];
  logic [2:0] rom_d1 = '0;
  always @(posedge clk) begin
    rom_d1     <= (index_y < NROWS && index_x < LANES) ? rom[index_y[3:0]][index_x] : 3'd0;
    data_state <= rom_d1;
  end

  typedef struct {
    logic        pause;
    logic [2:0]  ix;
    logic        strobe;
    logic [10:0] rptr;
    logic        busy;
  } vec_t;

  int n_vec = 0;
  int n_miss = 0;
  int rel = 0;
  int play_len, n_strobe, n_done, ix_active, shift, done_rel;
  bit timed;
  logic [ROW_W-1:0] exp_rows[$];
  logic [ROW_W-1:0] model_win [WINDOW];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (cycle %0d after start)", name, act, exp, rel);
    end
  endtask

  function automatic logic [ROW_W-1:0] rom_row(input int r);
    logic [ROW_W-1:0] v = '0;
    for (int k = 0; k < LANES; k++) v[k*3 +: 3] = rom[r][k];
    return v;
  endfunction

  function automatic logic [WIN_W-1:0] model_pack();
    logic [WIN_W-1:0] v = '0;
    for (int r = 0; r < WINDOW; r++) v[r*ROW_W +: ROW_W] = model_win[r];
    return v;
  endfunction

  // Unpaused timing: each chart row costs TICK_DIV waiting cycles + 7 fetch + 1 commit;
  // each blank row costs one TICK_DIV period.
  function automatic int strobe_time(input int k);
    if (k < play_len) return k * (TICK_DIV + 8) + TICK_DIV + 7;
    return play_len * (TICK_DIV + 8) + (k - play_len + 1) * TICK_DIV;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic observe();
    if (index_x != 3'd0) begin
      ix_active++;
      check("index_y_during_fetch", index_y, 128'(n_strobe));
    end
    if (row_strobe) begin
      if (n_strobe >= exp_rows.size()) begin
        check("strobe_count_limit", n_strobe + 1, exp_rows.size());
      end else begin
        for (int r = WINDOW - 1; r > 0; r--) model_win[r] = model_win[r-1];
        model_win[0] = exp_rows[n_strobe];
        check("window_on_strobe", window, model_pack());
        check("row_ptr_on_strobe", row_ptr, (n_strobe < play_len) ? n_strobe + 1 : play_len);
        if (timed) check("strobe_time", rel, strobe_time(n_strobe) + shift);
        n_strobe++;
      end
    end
    if (done) begin
      n_done++;
      done_rel = rel;
      check("done_with_last_strobe", n_strobe, exp_rows.size());
      check("window_at_done", window, 0);
    end
  endtask

  task automatic start_play(input int len);
    play_len = len;
    map_len  = 11'(len);
    exp_rows.delete();
    for (int i = 0; i < len; i++) exp_rows.push_back(rom_row(i));
    for (int i = 0; i < WINDOW; i++) exp_rows.push_back('0);
    for (int r = 0; r < WINDOW; r++) model_win[r] = '0;
    n_strobe = 0; n_done = 0; ix_active = 0; shift = 0; done_rel = -1; timed = 1'b1;
    start = 1'b1;
    rel = -1;
    step();
    start = 1'b0;
    observe();
  endtask

  task automatic finish_play(input int max_cyc);
    int budget = max_cyc;
    while (n_done == 0 && budget > 0) begin
      step();
      observe();
      budget--;
    end
    check("done_seen", n_done, 1);
    if (timed) check("done_time", done_rel, play_len * (TICK_DIV + 8) + WINDOW * TICK_DIV + shift);
    check("row_ptr_at_end", row_ptr, play_len);
    step();
    observe();
    check("busy_after_done", busy, 0);
    repeat (3) begin step(); observe(); end
    check("done_single_pulse", n_done, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, want summary line");
    $fatal(1);
  end

  initial begin
    vec_t tbl [16];
    int   quiet;

    for (int r = 0; r < NROWS; r++)
      for (int k = 0; k < LANES; k++) rom[r][k] = 3'($urandom_range(0, 7));
    rom[0][0] = 3'd1; rom[0][1] = 3'd0; rom[0][2] = 3'd2; rom[0][3] = 3'd0; rom[0][4] = 3'd1;

    //           pause  index_x strobe row_ptr busy
    tbl[0]  = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[1]  = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[2]  = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[3]  = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[4]  = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[5]  = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[6]  = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[7]  = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[8]  = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[9]  = '{1'b1, 3'd1, 1'b0, 11'd0, 1'b1};
    tbl[10] = '{1'b1, 3'd2, 1'b0, 11'd0, 1'b1};
    tbl[11] = '{1'b1, 3'd3, 1'b0, 11'd0, 1'b1};
    tbl[12] = '{1'b0, 3'd4, 1'b0, 11'd0, 1'b1};
    tbl[13] = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[14] = '{1'b0, 3'd0, 1'b0, 11'd0, 1'b1};
    tbl[15] = '{1'b0, 3'd0, 1'b1, 11'd1, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_window", window, 0);
    check("reset_row_ptr", row_ptr, 0);
    check("reset_index_x", index_x, 0);
    check("reset_index_y", index_y, 0);
    check("reset_row_strobe", row_strobe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    step();

    // First row timing from the vector table (pause pulses land inside FETCH), then full playback
    start_play(3);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin step(); observe(); end
      check("tbl_index_x", index_x, tbl[i].ix);
      check("tbl_row_strobe", row_strobe, tbl[i].strobe);
      check("tbl_row_ptr", row_ptr, tbl[i].rptr);
      check("tbl_busy", busy, tbl[i].busy);
      pause = tbl[i].pause;
    end
    check("row0_lanes", window[ROW_W-1:0], 15'b001_000_010_000_001);
    check("upper_rows_empty", window[WIN_W-1:ROW_W], 0);
    finish_play(400);

    // Pause for 20 cycles in the middle of WAIT_TICK
    start_play(2);
    while (rel < 18) begin step(); observe(); end
    pause = 1'b1;
    shift = 20;
    repeat (20) begin step(); observe(); end
    pause = 1'b0;
    finish_play(400);

    // Abort during the fetch of row 1 at f = 3, then replay from row 0
    start_play(3);
    while (rel < 27) begin step(); observe(); end
    check("abort_at_f3_index_x", index_x, 3);
    check("abort_pre_window_loaded", window[ROW_W-1:0], rom_row(0));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_window", window, 0);
    check("abort_row_ptr", row_ptr, 0);
    check("abort_row_strobe", row_strobe, 0);
    check("abort_done", done, 0);
    quiet = 0;
    repeat (40) begin
      step();
      if (row_strobe || done || busy) quiet++;
    end
    check("quiet_after_abort", quiet, 0);
    start_play(3);
    finish_play(400);

    // Empty chart: no ROM fetch, just the blank-row drain
    start_play(0);
    finish_play(200);
    check("no_index_x_activity", ix_active, 0);

    // start pulses while busy must not disturb the row progression
    start_play(4);
    while (rel < 100) begin
      start = (rel == 10 || rel == 20 || rel == 90);
      step();
      observe();
    end
    start = 1'b0;
    finish_play(400);

    // Randomized charts with random pause and stray start pulses
    for (int t = 0; t < 6; t++) begin
      int budget;
      for (int r = 1; r < NROWS; r++)
        for (int k = 0; k < LANES; k++) rom[r][k] = 3'($urandom_range(0, 7));
      start_play($urandom_range(1, 12));
      timed  = 1'b0;
      budget = 2000;
      while (n_done == 0 && budget > 0) begin
        pause = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 30) == 0);
        step();
        observe();
        budget--;
      end
      pause = 1'b0;
      start = 1'b0;
      finish_play(10);
    end

    // Asynchronous reset in DRAIN_WAIT, between clock edges
    start_play(1);
    while (rel < 40) begin step(); observe(); end
    check("pre_reset_window_loaded", window != '0, 1);
    check("pre_reset_row_ptr", row_ptr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_window", window, 0);
    check("async_row_ptr", row_ptr, 0);
    check("async_index_x", index_x, 0);
    check("async_index_y", index_y, 0);
    check("async_row_strobe", row_strobe, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Sequences chart playback from the 5-lane note map ROM (index_y/index_x in, registered data_state out, 2-cycle read latency, len = chart length).
- On each beat tick, fetches one chart row (all 5 lanes) and shifts it into a WINDOW-row scrolling buffer.
- The renderer and hit judge consume that buffer.
- Handles start, pause, abort and end-of-chart drain.

Parameters:
- TICK_DIV, 25_000_000: clk cycles per beat tick (valid range 8 or more).
- WINDOW, 8: rows held in the visible scroll buffer.
- LANES, 5: lanes per row, fixed by the map ROM (index_x 0..4).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins playback from row 0. Ignored unless IDLE.
- pause  in  1  level; freezes the tick counter while high.
- abort  in  1  single-cycle pulse; returns to IDLE.
- map_len  in  11  chart length in rows, from the map ROM len.
- index_y  out  100  row address to the map ROM (zero-extended row pointer).
- index_x  out  3  lane address to the map ROM.
- data_state  in  3  map ROM note state for the address issued 2 cycles earlier.
- window  out  WINDOW*LANES*3  scroll buffer. Row r occupies bits [r*15 +: 15]; lane k of that row is bits [k*3 +: 3]. Row 0 is newest.
- row_ptr  out  11  next chart row to fetch.
- row_strobe  out  1  1-cycle pulse on the cycle window updates.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse when playback completes.

Behaviour:
- Reset (async, rst_n low) values:
  - state = IDLE; window = 0; row_ptr = 0; index_y = 0; index_x = 0; tick counter = 0.
  - row_strobe = 0, done = 0, busy = 0.
- States: IDLE, WAIT_TICK, FETCH, COMMIT, DRAIN_WAIT, DONE.
- IDLE:
  - start -> WAIT_TICK; row_ptr = 0, tick counter = 0, window cleared.
- Tick counter:
  - Counts in WAIT_TICK and DRAIN_WAIT only, and only while pause = 0.
  - Holds its value while pause = 1.
  - tick fires when the count reaches TICK_DIV-1; the counter then wraps to 0.
  - First tick arrives TICK_DIV cycles after start (pause held low).
- WAIT_TICK on tick:
  - row_ptr < map_len -> FETCH.
  - otherwise -> DRAIN_WAIT.
- FETCH (exactly 7 cycles, f = 0..6):
  - Cycles f = 0..4: drive index_y = row_ptr, index_x = f.
  - Cycles f = 2..6: capture data_state into lane f-2 of the row assembly register.
  - index_x returns to 0 after f = 4.
  - pause has no effect in FETCH.
- COMMIT (1 cycle):
  - window shifts up one row (row WINDOW-1 discarded); row 0 = assembled row.
  - row_ptr += 1; row_strobe = 1.
  - -> WAIT_TICK.
- DRAIN_WAIT:
  - On each tick, shift an all-zero row into window and pulse row_strobe.
  - After WINDOW such shifts -> DONE.
- DONE (1 cycle): done = 1 -> IDLE. window is left all-zero.
- map_len = 0: the first tick goes straight to DRAIN_WAIT; no ROM fetch occurs.
- map_len is sampled continuously. The team guarantees it is stable while busy.
- abort, in any non-IDLE state:
  - Next state is IDLE; window cleared, row_ptr = 0.
  - No done pulse; a fetch in progress is discarded.
  - abort has priority over tick and FETCH completion.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: abort wins, remain IDLE.
- Width rules:
  - Lane values are passed through unmodified (3 bits; values 0/1/2 are note types).
  - row_ptr never exceeds map_len.

Test Plan:
- Basic fetch timing:
  - Setup: TICK_DIV = 8, map_len = 3, ROM row0 = {lanes 0..4: 1,0,2,0,1}.
  - Stimulus: start.
  - Required: index_x sequence 0,1,2,3,4 at cycles 8..12 after start; row_strobe at cycle 15; window[14:0] = 15'b001_000_010_000_001.
- Full playback:
  - Setup: map_len = 3, WINDOW = 8.
  - Required: exactly 3 fetch rows, then 8 zero-row strobes; done pulses once, 11 ticks after start; window = 0 at done; busy low the next cycle.
- Pause:
  - Stimulus: assert pause for 20 cycles mid-WAIT_TICK.
  - Required: next row_strobe delayed by exactly 20 cycles.
  - Stimulus: assert pause during FETCH.
  - Required: fetch completes unaffected.
- Abort:
  - Stimulus: abort at FETCH cycle f = 3.
  - Required: IDLE next cycle; window = 0, row_ptr = 0, no row_strobe, no done.
  - Then: a subsequent start replays from row 0.
- Boundary:
  - Stimulus: map_len = 0, start.
  - Required: no index_x activity; 8 zero strobes; then done.
  - Stimulus: start pulsed while busy.
  - Required: row_ptr progression unchanged.
- Async reset:
  - Stimulus: drop rst_n mid-DRAIN_WAIT, between clock edges.
  - Required: all outputs at reset values immediately, without a clock edge.
